// File: rtl/syn_md_capture.sv
// -----------------------------------------------------------------------------
// syn_md_capture
//
// Purpose:
//   Takes the asynchronous sync/mode level produced by syn_md_combine into the
//   clk domain and turns it into something the NMR sequencer can trust:
//     1. two-flop synchroniser
//     2. glitch filter: a new level must be seen for FILT_LEN consecutive
//        synchronised cycles before it is accepted
//     3. rising-edge detection on the filtered level
//     4. rise-to-rise period measurement, lock tracking and loss-of-sync
//        (timeout) detection
//
// Optional feature (compile-time macro SYN_MD_HIGH_TIME_EN):
//   When defined, the filtered high duration is measured and reported on
//   high_time / high_vld at every falling edge. When undefined those ports
//   are tied to 0 and no high-time counter exists.
//
// Parameters:
//   FILT_LEN  cycles a new synchronised level must persist to be accepted (>=1)
//   CNT_W     width of the period counter and of period / high_time
//   LOCK_CNT  consecutive in-tolerance periods needed to assert locked (>=1)
//   TOL       largest |period(n) - period(n-1)| still counted as a match
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   syn_md_temp  in   asynchronous sync/mode level
//   syn_md       out  synchronised, filtered level
//   rise_p       out  one-cycle pulse on each accepted rising edge of syn_md
//   period       out  clk cycles between the last two rise_p pulses
//   period_vld   out  one-cycle pulse, period updated this cycle
//   locked       out  sync period stable
//   no_sync      out  no valid sync (reset / timeout), cleared by next rise_p
//   high_time    out  filtered high duration in clk cycles (optional)
//   high_vld     out  one-cycle pulse, high_time updated (optional)
// -----------------------------------------------------------------------------
module syn_md_capture #(
   parameter int FILT_LEN = 4,
   parameter int CNT_W    = 24,
   parameter int LOCK_CNT = 4,
   parameter int TOL      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             syn_md_temp,
   output logic             syn_md,
   output logic             rise_p,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             locked,
   output logic             no_sync,
   output logic [CNT_W-1:0] high_time,
   output logic             high_vld
);

   // Counter widths; a width of at least 1 keeps FILT_LEN/LOCK_CNT == 1 legal.
   localparam int FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int LOCK_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);

   // ------------------------------------------------------------------------
   // Synchroniser: sync_reg[0] is the metastability catcher (s1),
   // sync_reg[1] is the first flop whose value the logic may use (s2).
   // ------------------------------------------------------------------------
   logic [1:0] sync_reg;
   logic       s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], syn_md_temp};
      end
   end

   assign s2 = sync_reg[1];

   // ------------------------------------------------------------------------
   // Glitch filter. filt_cnt counts how long s2 has disagreed with the
   // accepted level; any agreement restarts the count, so only an
   // uninterrupted run of FILT_LEN disagreeing samples flips syn_md.
   // ------------------------------------------------------------------------
   logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
   logic              syn_md_reg, syn_md_next;
   logic              rise_now;

   always_comb begin
      filt_cnt_next = filt_cnt_reg;
      syn_md_next   = syn_md_reg;
      if (s2 == syn_md_reg) begin
         filt_cnt_next = '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
         syn_md_next   = s2;
         filt_cnt_next = '0;
      end else begin
         filt_cnt_next = filt_cnt_reg + 1'b1;
      end
   end

   // Rising edge of the filtered level is known combinationally, so rise_p
   // can be registered on the same edge at which syn_md goes high.
   assign rise_now = ~syn_md_reg & syn_md_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_cnt_reg <= '0;
         syn_md_reg   <= 1'b0;
      end else begin
         filt_cnt_reg <= filt_cnt_next;
         syn_md_reg   <= syn_md_next;
      end
   end

   // ------------------------------------------------------------------------
   // Period measurement and loss-of-sync detection.
   // per_cnt is loaded with 1 on a rise so that, at the next rise, it holds
   // exactly the number of clk cycles between the two rises. It saturates at
   // CNT_MAX; sitting saturated with no rise arriving is the timeout.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
   logic [CNT_W-1:0] period_reg, period_next;
   logic             period_vld_reg, period_vld_next;
   logic             rise_p_reg;
   logic             armed_reg, armed_next;
   logic             no_sync_reg, no_sync_next;
   logic             per_sat;
   logic             timeout_now;

   assign per_sat     = (per_cnt_reg == CNT_MAX);
   // A rise in the saturated cycle is a legal (maximal) measurement, so the
   // rise wins over the timeout.
   assign timeout_now = per_sat & ~rise_now;

   always_comb begin
      per_cnt_next    = per_cnt_reg;
      period_next     = period_reg;
      period_vld_next = 1'b0;
      armed_next      = armed_reg;
      no_sync_next    = no_sync_reg;

      if (rise_now) begin
         per_cnt_next = CNT_ONE;
         // The first rise after reset/timeout only arms the measurement: there
         // is no earlier rise to measure against.
         if (armed_reg) begin
            period_next     = per_cnt_reg;
            period_vld_next = 1'b1;
         end
         armed_next   = 1'b1;
         no_sync_next = 1'b0;
      end else begin
         if (!per_sat) begin
            per_cnt_next = per_cnt_reg + 1'b1;
         end
         if (timeout_now) begin
            armed_next   = 1'b0;
            no_sync_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt_reg    <= '0;
         period_reg     <= '0;
         period_vld_reg <= 1'b0;
         rise_p_reg     <= 1'b0;
         armed_reg      <= 1'b0;
         no_sync_reg    <= 1'b1;
      end else begin
         per_cnt_reg    <= per_cnt_next;
         period_reg     <= period_next;
         period_vld_reg <= period_vld_next;
         rise_p_reg     <= rise_now;
         armed_reg      <= armed_next;
         no_sync_reg    <= no_sync_next;
      end
   end

   // ------------------------------------------------------------------------
   // Lock tracking. Each new period is compared against the previous one.
   // The comparison uses the value being loaded into period this very edge
   // (per_cnt_reg), so locked changes together with period_vld.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0]  prev_reg, prev_next;
   logic              prev_vld_reg, prev_vld_next;
   logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
   logic              locked_reg, locked_next;
   logic [CNT_W-1:0]  per_diff;
   logic              in_tol;

   assign per_diff = (per_cnt_reg >= prev_reg) ? (per_cnt_reg - prev_reg)
                                               : (prev_reg - per_cnt_reg);
   assign in_tol   = (per_diff <= TOL_C);

   always_comb begin
      prev_next     = prev_reg;
      prev_vld_next = prev_vld_reg;
      lock_cnt_next = lock_cnt_reg;
      locked_next   = locked_reg;

      if (period_vld_next) begin
         prev_next = per_cnt_reg;
         if (!prev_vld_reg) begin
            prev_vld_next = 1'b1;
         end else if (in_tol) begin
            // lock_cnt stops at LOCK_LAST; further matches just hold lock.
            if (lock_cnt_reg == LOCK_LAST) begin
               locked_next = 1'b1;
            end else begin
               lock_cnt_next = lock_cnt_reg + 1'b1;
            end
         end else begin
            lock_cnt_next = '0;
            locked_next   = 1'b0;
         end
      end else if (timeout_now) begin
         prev_vld_next = 1'b0;
         lock_cnt_next = '0;
         locked_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg     <= '0;
         prev_vld_reg <= 1'b0;
         lock_cnt_reg <= '0;
         locked_reg   <= 1'b0;
      end else begin
         prev_reg     <= prev_next;
         prev_vld_reg <= prev_vld_next;
         lock_cnt_reg <= lock_cnt_next;
         locked_reg   <= locked_next;
      end
   end

   // ------------------------------------------------------------------------
   // High-time measurement (optional).
   // ------------------------------------------------------------------------
`ifdef SYN_MD_HIGH_TIME_EN
   logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
   logic [CNT_W-1:0] high_time_reg, high_time_next;
   logic             high_vld_reg, high_vld_next;
   logic             fall_now;

   assign fall_now = syn_md_reg & ~syn_md_next;

   always_comb begin
      hi_cnt_next    = hi_cnt_reg;
      high_time_next = high_time_reg;
      high_vld_next  = 1'b0;

      // Loaded with 1 on the rise, so at the fall it equals the number of
      // cycles syn_md was high.
      if (rise_now) begin
         hi_cnt_next = CNT_ONE;
      end else if (syn_md_reg && (hi_cnt_reg != CNT_MAX)) begin
         hi_cnt_next = hi_cnt_reg + 1'b1;
      end

      // Only report highs that began with a rise seen since reset/timeout.
      if (fall_now && armed_reg) begin
         high_time_next = hi_cnt_reg;
         high_vld_next  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_cnt_reg    <= '0;
         high_time_reg <= '0;
         high_vld_reg  <= 1'b0;
      end else begin
         hi_cnt_reg    <= hi_cnt_next;
         high_time_reg <= high_time_next;
         high_vld_reg  <= high_vld_next;
      end
   end

   assign high_time = high_time_reg;
   assign high_vld  = high_vld_reg;
`else
   assign high_time = '0;
   assign high_vld  = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign syn_md     = syn_md_reg;
   assign rise_p     = rise_p_reg;
   assign period     = period_reg;
   assign period_vld = period_vld_reg;
   assign locked     = locked_reg;
   assign no_sync    = no_sync_reg;

endmodule

// File: tb/tb_syn_md_capture.sv
// -----------------------------------------------------------------------------
// tb_syn_md_capture
//
// Directed bench for syn_md_capture with FILT_LEN=4, CNT_W=8, LOCK_CNT=4,
// TOL=8. Inputs are driven and outputs sampled 1 ns after the falling clock
// edge. A monitor logs every rise_p / high_vld event; the main sequence then
// compares the logs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_syn_md_capture;

   localparam int FILT_LEN = 4;
   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
   localparam int TOL      = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             syn_md_temp;
   logic             syn_md;
   logic             rise_p;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             locked;
   logic             no_sync;
   logic [CNT_W-1:0] high_time;
   logic             high_vld;

   syn_md_capture #(
      .FILT_LEN (FILT_LEN),
      .CNT_W    (CNT_W),
      .LOCK_CNT (LOCK_CNT),
      .TOL      (TOL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .syn_md_temp (syn_md_temp),
      .syn_md      (syn_md),
      .rise_p      (rise_p),
      .period      (period),
      .period_vld  (period_vld),
      .locked      (locked),
      .no_sync     (no_sync),
      .high_time   (high_time),
      .high_vld    (high_vld)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Counters and checking task
   // ------------------------------------------------------------------------
   int tests_run = 0;
   int tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0d", tag, got);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor: samples at the falling edge
   // ------------------------------------------------------------------------
   int         cyc = 0;
   int         rise_cnt = 0;
   int         last_rise_cyc = 0;
   int         syn_hi_cyc = 0;
   int         hv_cnt = 0;
   logic       lg_vld  [256];
   logic [7:0] lg_per  [256];
   logic       lg_lock [256];
   logic       lg_ns   [256];
   logic [7:0] hv_log  [256];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (syn_md === 1'b1) syn_hi_cyc <= syn_hi_cyc + 1;
      if (rise_p === 1'b1) begin
         if (rise_cnt < 256) begin
            lg_vld[rise_cnt]  <= period_vld;
            lg_per[rise_cnt]  <= period;
            lg_lock[rise_cnt] <= locked;
            lg_ns[rise_cnt]   <= no_sync;
         end
         rise_cnt      <= rise_cnt + 1;
         last_rise_cyc <= cyc + 1;
      end
      if (high_vld === 1'b1) begin
         if (hv_cnt < 256) hv_log[hv_cnt] <= high_time;
         hv_cnt <= hv_cnt + 1;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input int n, input logic v);
      for (int i = 0; i < n; i++) begin
         tick();
         syn_md_temp = v;
      end
   endtask

   task automatic square(input int hi, input int lo);
      drive(hi, 1'b1);
      drive(lo, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(3, 1'b0);
      rst = 1'b0;
   endtask

   // Watchdog: the whole run is a few thousand cycles.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   int base;
   int hv_base;
   int hi_before;
   int guard;
   int exp_per3 [10] = '{100, 100, 110, 100, 100, 100, 100, 100, 100, 105};
   int exp_lk3  [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
   int lens_hi  [9]  = '{50, 60, 50, 50, 50, 50, 50, 50, 55};

   initial begin
      rst         = 1'b1;
      syn_md_temp = 1'b0;
      drive(3, 1'b0);

      // ---- reset state ----
      check_val("rst_syn_md",     syn_md,     0);
      check_val("rst_rise_p",     rise_p,     0);
      check_val("rst_period",     period,     0);
      check_val("rst_period_vld", period_vld, 0);
      check_val("rst_locked",     locked,     0);
      check_val("rst_no_sync",    no_sync,    1);
      check_val("rst_high_time",  high_time,  0);
      check_val("rst_high_vld",   high_vld,   0);
      rst = 1'b0;
      drive(5, 1'b0);

      // ---- filter: 3-cycle pulse is rejected ----
      hi_before = syn_hi_cyc;
      base      = rise_cnt;
      drive(3, 1'b1);
      drive(15, 1'b0);
      check_val("short_pulse_syn_md_cycles", syn_hi_cyc - hi_before, 0);
      check_val("short_pulse_rises", rise_cnt - base, 0);

      // ---- filter: 4-cycle pulse is accepted, rise_p at E0+5 ----
      hi_before = syn_hi_cyc;
      tick();
      syn_md_temp = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick();
         syn_md_temp = (j < 4);
         if (j == 5) begin
            check_val("pulse4_rise_p_e0p4", rise_p, 0);
            check_val("pulse4_syn_md_e0p4", syn_md, 0);
         end
         if (j == 6) begin
            check_val("pulse4_rise_p_e0p5", rise_p, 1);
            check_val("pulse4_syn_md_e0p5", syn_md, 1);
            check_val("pulse4_first_vld",   period_vld, 0);
         end
         if (j == 7) check_val("pulse4_rise_p_once", rise_p, 0);
         if (j == 9) check_val("pulse4_syn_md_last", syn_md, 1);
         if (j == 10) check_val("pulse4_syn_md_fall", syn_md, 0);
      end
      check_val("pulse4_high_cycles", syn_hi_cyc - hi_before, 4);

      // ---- square wave 50/50: first measurement, lock on 6th rise ----
      do_reset();
      tick();
      check_val("sq_no_sync_before", no_sync, 1);
      base = rise_cnt;
      for (int k = 0; k < 6; k++) square(50, 50);
      check_val("sq_rise_count", rise_cnt - base, 6);
      for (int k = 0; k < 6; k++) begin
         check_val($sformatf("sq_r%0d_vld", k + 1), lg_vld[base+k], (k > 0));
         if (k > 0) check_val($sformatf("sq_r%0d_period", k + 1), lg_per[base+k], 100);
         check_val($sformatf("sq_r%0d_locked", k + 1), lg_lock[base+k], (k == 5));
         check_val($sformatf("sq_r%0d_no_sync", k + 1), lg_ns[base+k], 0);
      end

      // ---- lock loss at 110, relock, 105 keeps lock ----
      for (int k = 0; k < 9; k++) square(lens_hi[k], 50);
      drive(50, 1'b1);
      for (int k = 0; k < 10; k++) begin
         check_val($sformatf("lk_r%0d_period", k + 7), lg_per[base+6+k], exp_per3[k]);
         check_val($sformatf("lk_r%0d_locked", k + 7), lg_lock[base+6+k], exp_lk3[k]);
      end

      // ---- timeout 255 cycles after the last rise ----
      guard = 0;
      while ((cyc != last_rise_cyc + 254) && (guard < 400)) begin
         tick();
         syn_md_temp = 1'b0;
         guard++;
      end
      check_val("to_wait_in_budget", (guard < 400), 1);
      check_val("to_no_sync_at_254", no_sync, 0);
      check_val("to_locked_at_254",  locked,  1);
      tick();
      check_val("to_no_sync_at_255", no_sync, 1);
      check_val("to_locked_at_255",  locked,  0);
      square(50, 50);
      check_val("to_next_rise_vld",     lg_vld[base+16],  0);
      check_val("to_next_rise_no_sync", lg_ns[base+16],   0);
      check_val("to_next_rise_locked",  lg_lock[base+16], 0);

      // ---- reset mid-stream with input held high ----
      drive(20, 1'b1);
      rst = 1'b1;
      tick();
      check_val("mid_rst_syn_md",  syn_md,  0);
      check_val("mid_rst_period",  period,  0);
      check_val("mid_rst_no_sync", no_sync, 1);
      check_val("mid_rst_locked",  locked,  0);
      rst = 1'b0;
      drive(5, 1'b1);
      check_val("mid_rst_rise_p_early", rise_p, 0);
      tick();
      check_val("mid_rst_rise_p",     rise_p,     1);
      check_val("mid_rst_period_vld", period_vld, 0);

      // ---- high-time: 30 high / 70 low ----
      hv_base = hv_cnt;
      base    = rise_cnt;
      drive(70, 1'b0);
      for (int k = 0; k < 3; k++) square(30, 70);
      check_val("ht_r3_period", lg_per[base+2], 100);
`ifdef SYN_MD_HIGH_TIME_EN
      check_val("ht_pulse_count", hv_cnt - hv_base, 4);
      for (int k = 1; k < 4; k++)
         check_val($sformatf("ht_high_time_%0d", k), hv_log[hv_base+k], 30);
`else
      check_val("ht_pulse_count", hv_cnt - hv_base, 0);
      check_val("ht_high_time",   high_time, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/syn_md_capture.md
Name: syn_md_capture

Overview:
- Downstream consumer of the combinational sync/mode line `syn_md_temp` from `syn_md_combine`.
- Brings it into the system clock domain through a 2-FF synchroniser, then a glitch filter, then rising-edge detection.
- Measures the sync period and flags lock/loss so the NMR sequencer can gate acquisition on a stable sync.

Parameters:
- FILT_LEN, 4: consecutive synchronised cycles a new level must hold before it is accepted (>=1).
- CNT_W, 24: width of the period counter and of the `period` output.
- LOCK_CNT, 4: consecutive in-tolerance period comparisons needed to assert `locked` (>=1).
- TOL, 8: maximum |period(n) - period(n-1)| in clk cycles still counted as a match.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- syn_md_temp  in  1  asynchronous sync/mode level from `syn_md_combine`.
- syn_md  out  1  synchronised, filtered level.
- rise_p  out  1  one-cycle pulse on each accepted rising edge of `syn_md`.
- period  out  CNT_W  clk cycles between the last two `rise_p` pulses.
- period_vld  out  1  one-cycle pulse; `period` updated this cycle.
- locked  out  1  sync period stable.
- no_sync  out  1  no valid sync; set at reset or timeout, cleared by the next `rise_p`.
- high_time  out  CNT_W  filtered high duration (optional feature).
- high_vld  out  1  one-cycle pulse; `high_time` updated (optional feature).

Behaviour:
- Reset is synchronous and active-high: the block has one clock, `clk`, and reset `rst` is sampled on its rising edge.
- Reset values:
  - s1, s2, `syn_md`, `rise_p`, `period_vld`, `locked`, `high_vld` = 0.
  - `period`, `high_time`, per_cnt, filt_cnt, lock_cnt = 0.
  - `no_sync` = 1.
  - armed, prev_vld = 0.
- Synchroniser:
  - s1 <= `syn_md_temp`; s2 <= s1.
  - Edge E0 is the edge at which s1 first captures a new level.
- Filter, evaluated every edge:
  - If s2 == `syn_md`: filt_cnt <= 0.
  - Else if filt_cnt == FILT_LEN-1: `syn_md` <= s2 and filt_cnt <= 0.
  - Else: filt_cnt++.
  - An input level held for N >= FILT_LEN cycles is accepted; `syn_md` changes at edge E0+FILT_LEN+1.
  - An input level held for N < FILT_LEN cycles is rejected with no output activity.
- Edge detection:
  - `rise_p` is registered high on the same edge at which `syn_md` goes 0->1, and is low otherwise.
- Period counter:
  - On a rise edge: per_cnt <= 1.
  - Otherwise: per_cnt++ while per_cnt < 2^CNT_W-1.
  - Periodic input with period P cycles gives `period` = P exactly.
- On a rise edge:
  - If armed: `period` <= per_cnt and `period_vld` pulses on the same edge as `rise_p`.
  - armed <= 1 and `no_sync` <= 0.
  - The first rise after reset or timeout produces no `period_vld`.
- Lock logic, evaluated on each `period_vld`:
  - If !prev_vld: store period as prev; prev_vld <= 1.
  - Else, if |new - prev| <= TOL: if lock_cnt == LOCK_CNT-1, `locked` <= 1; else lock_cnt++.
  - Else: lock_cnt <= 0 and `locked` <= 0.
  - Every `period_vld` updates prev.
  - `locked` therefore first asserts on the (LOCK_CNT+2)-th rise.
- Timeout:
  - Fires when per_cnt == 2^CNT_W-1 and the next edge carries no rise.
  - On timeout: `no_sync` <= 1; armed, prev_vld, `locked`, lock_cnt <= 0; per_cnt holds saturated.
  - A rise in the saturated cycle is a normal measurement with `period` = 2^CNT_W-1; no timeout occurs.
- Simultaneous events:
  - A rise always has priority over a timeout.
  - A fall cannot coincide with a rise.
- Reset mid-operation:
  - All state is cleared at the next edge.
  - If the input is held high across reset, one `rise_p` occurs FILT_LEN+2 edges after `rst` deasserts, with no `period_vld`.

Optional Feature:
- Macro: SYN_MD_HIGH_TIME_EN.
- Defined:
  - hi_cnt <= 1 on a rise; hi_cnt++ (saturating) while `syn_md` is high.
  - On a `syn_md` 1->0 edge while armed: `high_time` <= hi_cnt and `high_vld` pulses one cycle.
  - A high of H cycles gives `high_time` = H.
- Undefined:
  - `high_time` and `high_vld` are driven constant 0.
  - No hi_cnt logic is synthesised.
- Ports are present in both builds.

Test Plan:
- FILT_LEN=4:
  - Input high pulses of 3 cycles give no `syn_md` change and no `rise_p`.
  - A 4-cycle high pulse sets `syn_md` high for 4 cycles, with `rise_p` at E0+5.
- Square wave with period 100 (50 high), LOCK_CNT=4, TOL=8:
  - First `rise_p` has no `period_vld`.
  - Subsequent `period` = 100.
  - `locked` rises with the 6th `rise_p`.
  - `no_sync` falls at the 1st `rise_p`.
- Locked at 100:
  - One period of 110 (|diff| = 10 > TOL) gives `locked` = 0 at that `period_vld`.
  - Relock requires 4 further matches.
  - A period of 105 keeps `locked` = 1.
- CNT_W=8:
  - Stop input after lock; 255 cycles after the last rise, `no_sync` = 1 and `locked` = 0.
  - The next rise gives no `period_vld`, and `no_sync` = 0.
- Assert `rst` for 1 cycle mid-stream with the input high:
  - All outputs return to reset values next cycle (`no_sync` = 1).
  - `rise_p` follows FILT_LEN+2 cycles after release.
- SYN_MD_HIGH_TIME_EN defined, 30-high / 70-low input:
  - `high_vld` pulses each fall with `high_time` = 30.
  - With the macro undefined, `high_time` = 0 and `high_vld` = 0.
